// File: rtl/alu_seq_pkg.sv
// Purpose: shared opcodes, FSM state type and latency helpers for the ALU op sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_seq_pkg;

   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_MUL = 4'b0100;
   localparam logic [3:0] OP_DIV = 4'b0101;
   localparam logic [3:0] OP_MOD = 4'b0110;

   // Datapath "ground" channel; driven whenever no operation is executing.
   localparam logic [3:0] OP_NONE = 4'b0000;

   // Width of the settle counter; covers latencies up to 255 cycles.
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic logic is_legal_op(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
             (op == OP_DIV) || (op == OP_MOD);
   endfunction

   // Settle cycles for a legal opcode; callers pass the instance latencies.
   function automatic logic [CNT_W-1:0] op_latency(input logic [3:0] op,
                                                   input int add_lat,
                                                   input int mul_lat,
                                                   input int div_lat);
      logic [CNT_W-1:0] lat;
      case (op)
         OP_ADD, OP_SUB: lat = CNT_W'(add_lat);
         OP_MUL:         lat = CNT_W'(mul_lat);
         OP_DIV, OP_MOD: lat = CNT_W'(div_lat);
         default:        lat = CNT_W'(1);
      endcase
      return lat;
   endfunction

endpackage

// File: rtl/alu_seq_lat_ctr.sv
// Purpose: loadable down-counter timing the datapath settle window.
// Latency: load takes effect on the next edge; done is combinational from the count.
// Backpressure: none; counts whenever count is high and the value is non-zero.
module alu_seq_lat_ctr
   import alu_seq_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         count,
   output logic         done,
   output logic [W-1:0] cnt
);

   // Load has priority; otherwise decrement and park at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (count && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   // The last settle cycle is the one where the count reads 1.
   assign done = (cnt == W'(1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Purpose: one-at-a-time controller in front of the combinational ALU; holds inputs, captures OUT/ERR.
// Latency: rsp_valid rises LAT edges after accept (same edge for illegal ops); accepts spaced >= LAT+2.
// Backpressure: req_ready low while busy; result held until rsp_ready. Optional ALU_SEQ_ACC_CHAIN_EN adds req_chain.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int RES_W   = 32,
   parameter int ADD_LAT = 1,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_in1,
   input  logic [DATA_W-1:0] req_in2,
   input  logic [3:0]        req_op,
`ifdef ALU_SEQ_ACC_CHAIN_EN
   input  logic              req_chain,
`endif
   output logic [DATA_W-1:0] dp_in1,
   output logic [DATA_W-1:0] dp_in2,
   output logic [3:0]        dp_op,
   input  logic [RES_W-1:0]  dp_out,
   input  logic [1:0]        dp_err,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [RES_W-1:0]  rsp_result,
   output logic [1:0]        rsp_err,
   output logic              rsp_illegal,
   output logic              busy,
   output logic [1:0]        sticky_err,
   input  logic              clr_sticky
);

   state_t            state;
   logic [DATA_W-1:0] in1_q;
   logic [DATA_W-1:0] in2_q;
   logic [3:0]        op_q;
   logic              accept;
   logic              legal;
   logic              ctr_done;
   logic [CNT_W-1:0]  ctr_val;
   logic              capture;
   logic [DATA_W-1:0] in1_sel;

   assign accept  = (state == IDLE) && req_valid;
   assign legal   = is_legal_op(req_op);
   assign capture = (state == EXEC) && ctr_done;

`ifdef ALU_SEQ_ACC_CHAIN_EN
   logic [DATA_W-1:0] last_res;

   assign in1_sel = req_chain ? last_res : req_in1;

   // Last legal result for accumulator chaining; illegal ops never touch it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_res <= '0;
      end else if (capture) begin
         last_res <= dp_out[DATA_W-1:0];
      end
   end
`else
   assign in1_sel = req_in1;
`endif

   alu_seq_lat_ctr #(
      .W(CNT_W)
   ) u_lat_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept && legal),
      .load_val (op_latency(req_op, ADD_LAT, MUL_LAT, DIV_LAT)),
      .count    (state == EXEC),
      .done     (ctr_done),
      .cnt      (ctr_val)
   );

   // FSM with operand latch and result capture registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in1_q       <= '0;
         in2_q       <= '0;
         op_q        <= OP_NONE;
         rsp_result  <= '0;
         rsp_err     <= 2'b00;
         rsp_illegal <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (legal) begin
                     in1_q <= in1_sel;
                     in2_q <= req_in2;
                     op_q  <= req_op;
                     state <= EXEC;
                  end else begin
                     // Datapath is left untouched; answer immediately.
                     rsp_result  <= '0;
                     rsp_err     <= 2'b00;
                     rsp_illegal <= 1'b1;
                     state       <= RESP;
                  end
               end
            end
            EXEC: begin
               if (ctr_done) begin
                  rsp_result  <= dp_out;
                  rsp_err     <= dp_err;
                  rsp_illegal <= 1'b0;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky error accumulation; a capture on the clear edge keeps its own bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_err <= 2'b00;
      end else if (capture) begin
         sticky_err <= (clr_sticky ? 2'b00 : sticky_err) | dp_err;
      end else if (clr_sticky) begin
         sticky_err <= 2'b00;
      end
   end

   // Operands keep their last value outside EXEC to avoid toggling the datapath.
   assign dp_in1    = in1_q;
   assign dp_in2    = in2_q;
   assign dp_op     = (state == EXEC) ? op_q : OP_NONE;
   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

endmodule
